alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 32-bit ALU for the CPU core.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand and opcode inputs, captures the ALU result and flags, writes the result back, and returns it on a response handshake.
- Holds the architectural status register; the ALU is an external instance evaluated on the falling clock edge.

---
 rtl/alu_sequencer_if.sv | 22 ++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction and response handshake bundle for the ALU sequencer
interface alu_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  // Issuing side: offers instructions and consumes responses.
  modport master (
    output instr_valid, instr, resp_ready,
    input  instr_ready, resp_valid, resp_data, resp_err
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, instr, resp_ready,
    output instr_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller sequencing the external 32-bit ALU
module alu_sequencer #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    bus,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_op,
  input  logic [31:0]       alu_out,
  input  logic [5:0]        alu_flags,
  output logic [5:0]        status,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
  output logic              busy
);

  localparam logic [4:0] OP_LD  = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SL  = 5'h09;
  localparam logic [4:0] OP_SR  = 5'h0A;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t state, state_nxt;

  logic [31:0]       regs [NREGS];
  logic [ADDR_W-1:0] rd_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic [5:0]        status_q;

  // Instruction fields
  logic [4:0]        f_op;
  logic [ADDR_W-1:0] f_rd, f_rs1, f_rs2;
  logic              f_imm_sel;
  logic [31:0]       f_imm;
  logic              unused_instr;

  assign f_op         = bus.instr[31:27];
  assign f_rd         = bus.instr[24 +: ADDR_W];
  assign f_rs1        = bus.instr[21 +: ADDR_W];
  assign f_rs2        = bus.instr[18 +: ADDR_W];
  assign f_imm_sel    = bus.instr[17];
  assign f_imm        = {{(32-IMM_W){1'b0}}, bus.instr[IMM_W-1:0]};
  assign unused_instr = bus.instr[16];

  logic        op_legal;
  logic [31:0] src_a, src_b;
  logic [31:0] issue_b;
  logic [4:0]  issue_op;
  logic        accept;

  assign src_a  = regs[f_rs1];
  assign src_b  = f_imm_sel ? f_imm : regs[f_rs2];
  assign accept = (state == S_IDLE) && bus.instr_valid;

  // Opcode legality and shift-operand shaping (zero shift becomes a pass-through LD)
  always_comb begin
    op_legal = 1'b0;
    issue_op = f_op;
    issue_b  = src_b;
    case (f_op)
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: op_legal = 1'b1;
      OP_SL, OP_SR: begin
        op_legal = 1'b1;
        if (src_b == 32'd0)
          issue_op = OP_LD;
        else if (src_b > 32'd32)
          issue_b = 32'd32;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.instr_valid) state_nxt = op_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand issue, result capture, writeback and status update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      status_q    <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      if (accept) begin
        if (op_legal) begin
          alu_a  <= src_a;
          alu_b  <= issue_b;
          alu_op <= issue_op;
          rd_q   <= f_rd;
        end else begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if (state == S_ISSUE) begin
        resp_data_q <= alu_out;
        resp_err_q  <= 1'b0;
        alu_op      <= '0;
        if (rd_q != '0)
          regs[rd_q] <= alu_out;
        if (alu_op != OP_LD)
          status_q <= alu_flags;
      end
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.resp_valid  = (state == S_RESP);
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign status          = status_q;
  assign busy            = (state != S_IDLE);
  assign dbg_data        = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed table-driven bench for alu_sequencer
module tb_alu_sequencer;

  localparam logic [4:0] LD  = 5'h01;
  localparam logic [4:0] ADD = 5'h03;
  localparam logic [4:0] SUB = 5'h04;
  localparam logic [4:0] AND = 5'h05;
  localparam logic [4:0] OR  = 5'h06;
  localparam logic [4:0] XOR = 5'h07;
  localparam logic [4:0] NOT = 5'h08;
  localparam logic [4:0] SL  = 5'h09;
  localparam logic [4:0] SR  = 5'h0A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic [5:0]  alu_flags;
  logic [5:0]  status;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags), .status(status),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] alu_eval(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic h, v, c, n, z, s;
    logic [32:0] sum;
    h = 1'b0; v = 1'b0; c = 1'b0; r = '0;
    case (op)
      LD:  r = a;
      ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0]; c = sum[32];
        h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB: begin
        r = a - b; c = a < b; h = a[3:0] < b[3:0];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      SL:  r = a << b;
      SR:  r = a >> b;
      default: r = '0;
    endcase
    n = r[31]; z = (r == 32'd0); s = n ^ v;
    return {h, s, v, c, n, z, r};
  endfunction

  // External ALU: evaluates on the falling edge, holds when idle
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out   <= '0;
      alu_flags <= '0;
    end else if (alu_op != 5'h00) begin
      {alu_flags, alu_out} <= alu_eval(alu_op, alu_a, alu_b);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2, input logic isel, input logic [15:0] imm);
    return {op, rd, rs1, rs2, isel, 1'b0, imm};
  endfunction

  logic [31:0] exp_regs [8];

  task automatic sweep_regs(input string tag);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      check($sformatf("%s r%0d", tag, r), dbg_data, exp_regs[r]);
    end
  endtask

  // Called just after a rising edge with the sequencer idle.
  task automatic run_instr(input logic [31:0] ins, output int lat, output logic [4:0] op_seen,
                           output logic [31:0] b_seen);
    check("instr_ready before issue", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    op_seen = alu_op;
    b_seen = alu_b;
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  exp_op;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [5:0]  exp_status;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [4:0] op_seen;
    logic [31:0] b_seen;
    logic [2:0] rd;

    vecs[0]  = '{enc(ADD, 1, 0, 0, 1, 16'd5),  ADD, 32'd5,         1'b0, 6'b000000, 1};
    vecs[1]  = '{enc(ADD, 2, 1, 0, 1, 16'd3),  ADD, 32'd8,         1'b0, 6'b000000, 1};
    vecs[2]  = '{enc(NOT, 1, 0, 0, 0, 16'd0),  NOT, 32'hFFFF_FFFF, 1'b0, 6'b010010, 1};
    vecs[3]  = '{enc(ADD, 3, 1, 0, 1, 16'd1),  ADD, 32'd0,         1'b0, 6'b100101, 1};
    vecs[4]  = '{enc(LD,  4, 1, 0, 0, 16'd0),  LD,  32'hFFFF_FFFF, 1'b0, 6'b100101, 1};
    vecs[5]  = '{enc(5'h02, 5, 1, 0, 1, 16'd7), 5'h00, 32'd0,      1'b1, 6'b100101, 0};
    vecs[6]  = '{enc(ADD, 1, 0, 0, 1, 16'd1),  ADD, 32'd1,         1'b0, 6'b000000, 1};
    vecs[7]  = '{enc(SUB, 6, 0, 0, 1, 16'd1),  SUB, 32'hFFFF_FFFF, 1'b0, 6'b110110, 1};
    vecs[8]  = '{enc(SL,  5, 1, 0, 1, 16'd0),  LD,  32'd1,         1'b0, 6'b110110, 1};
    vecs[9]  = '{enc(SL,  5, 1, 0, 1, 16'd31), SL,  32'h8000_0000, 1'b0, 6'b010010, 1};
    vecs[10] = '{enc(SR,  7, 5, 0, 1, 16'd40), SR,  32'd0,         1'b0, 6'b000001, 1};
    vecs[11] = '{enc(XOR, 6, 2, 1, 0, 16'd0),  XOR, 32'd9,         1'b0, 6'b000000, 1};
    vecs[12] = '{enc(AND, 6, 6, 2, 0, 16'd0),  AND, 32'd8,         1'b0, 6'b000000, 1};
    vecs[13] = '{enc(ADD, 0, 2, 0, 1, 16'd4),  ADD, 32'd12,        1'b0, 6'b000000, 1};
    vecs[14] = '{enc(SUB, 2, 2, 2, 0, 16'd0),  SUB, 32'd0,         1'b0, 6'b000001, 1};
    vecs[15] = '{enc(OR,  1, 4, 0, 0, 16'd0),  OR,  32'hFFFF_FFFF, 1'b0, 6'b010010, 1};

    for (int r = 0; r < 8; r++) exp_regs[r] = '0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.resp_ready = 1'b0;
    dbg_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset resp_data", bus.resp_data, 32'd0);
    check("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("reset alu_op", {27'd0, alu_op}, 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset status", {26'd0, status}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].ins, lat, op_seen, b_seen);
      check($sformatf("v%0d alu_op", i), {27'd0, op_seen}, {27'd0, vecs[i].exp_op});
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d resp_data", i), bus.resp_data, vecs[i].exp_data);
      check($sformatf("v%0d resp_err", i), {31'd0, bus.resp_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d status", i), {26'd0, status}, {26'd0, vecs[i].exp_status});
      take_resp();
      rd = vecs[i].ins[26:24];
      if (!vecs[i].exp_err && rd != 3'd0) exp_regs[rd] = vecs[i].exp_data;
      sweep_regs($sformatf("v%0d", i));
    end

    // Shift amount above 32 is clamped on the operand bus
    run_instr(enc(SR, 7, 1, 0, 1, 16'd40), lat, op_seen, b_seen);
    check("clamp alu_b", b_seen, 32'd32);
    check("clamp alu_op", {27'd0, op_seen}, {27'd0, SR});
    check("clamp resp_data", bus.resp_data, 32'd0);
    take_resp();

    // Response backpressure with a competing instruction offered
    run_instr(enc(ADD, 3, 0, 0, 1, 16'h1234), lat, op_seen, b_seen);
    exp_regs[3] = 32'h0000_1234;
    bus.instr = enc(ADD, 4, 0, 0, 1, 16'h5555);
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d resp_data", c), bus.resp_data, 32'h0000_1234);
      check($sformatf("bp%0d resp_valid", c), {31'd0, bus.resp_valid}, 32'd1);
      check($sformatf("bp%0d instr_ready", c), {31'd0, bus.instr_ready}, 32'd0);
    end
    bus.instr_valid = 1'b0;
    take_resp();
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check("idle resp_ready resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("idle resp_ready busy", {31'd0, busy}, 32'd0);
    sweep_regs("bp");

    // Reset during ISSUE drops the instruction
    bus.instr = enc(ADD, 5, 0, 0, 1, 16'h0077);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    check("mid busy before reset", {31'd0, busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid alu_op", {27'd0, alu_op}, 32'd0);
    check("mid resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("mid busy", {31'd0, busy}, 32'd0);
    check("mid instr_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("mid status", {26'd0, status}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) exp_regs[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("post reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    sweep_regs("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
